// File: rtl/synth_pkg.sv
// Shared constants for the synth audio path.
// Sample width, I2S framing and default bit-clock divider.
package synth_pkg;

  localparam int SAMPLE_W       = 24;
  localparam int I2S_SLOT_W     = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int BCLK_DIV_DEF   = 8;

endpackage

// File: rtl/i2s_dac_tx_if.sv
// Mixer-side and codec-side signals of the I2S DAC transmitter.
// master drives the sample stream, slave is the transmitter.
interface i2s_dac_tx_if
  import synth_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
);

  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              i_clr_flags;
  logic              o_bclk;
  logic              o_lrck;
  logic              o_dacdat;
  logic              o_fifo_full;
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output i_data,
    output i_valid,
    output i_clr_flags,
    input  o_bclk,
    input  o_lrck,
    input  o_dacdat,
    input  o_fifo_full,
    input  o_overflow,
    input  o_underflow
  );

  modport slave (
    input  i_data,
    input  i_valid,
    input  i_clr_flags,
    output o_bclk,
    output o_lrck,
    output o_dacdat,
    output o_fifo_full,
    output o_overflow,
    output o_underflow
  );

endinterface

// File: rtl/sample_fifo.sv
// Show-ahead synchronous FIFO for mixed samples.
// Caller guarantees no push when full unless popping.
module sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             full_q, full_d;

  always_comb begin
    wr_d   = wr_q + AW'(push);
    rd_d   = rd_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d = (cnt_d == (AW+1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wdata;
  end

  assign rdata = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = full_q;
  assign count = cnt_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// Mono I2S (Philips) transmitter fed by the voice mixer.
// Same sample goes out in both slots, 32-bit slots, MSB first.
module i2s_dac_tx
  import synth_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FIFO_DEPTH = 8,
  parameter int BCLK_DIV   = BCLK_DIV_DEF
) (
  input  logic         clk,
  input  logic         rst,
  i2s_dac_tx_if.slave  bus
);

  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BW = $clog2(I2S_FRAME_BITS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DW-1:0]     div_cnt_q, div_cnt_d;
  logic              bclk_q, bclk_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              lrck_q, lrck_d;
  logic              dac_q, dac_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;

  logic              wrap, fall, frame;
  logic              push, pop;
  logic              fifo_empty, fifo_full;
  logic [DATA_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic [I2S_SLOT_W-1:0] slot;
  logic [4:0]        k;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.i_data),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    wrap  = (div_cnt_q == DW'(BCLK_DIV - 1));
    fall  = wrap & bclk_q;
    frame = fall & (bit_cnt_q == BW'(I2S_FRAME_BITS - 1));
    pop   = frame & ~fifo_empty;
    push  = bus.i_valid
          & ((fifo_count < CW'(FIFO_DEPTH)) | pop);

    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = wrap ? ~bclk_q : bclk_q;
    bit_cnt_d = fall ? bit_cnt_q + 1'b1 : bit_cnt_q;
    lrck_d    = fall ? bit_cnt_d[BW-1] : lrck_q;

    shift_d = shift_q;
    if (frame) shift_d = fifo_empty ? '0 : fifo_rdata;

    // Slot word: one-bit delay, sample MSB first, zero pad.
    slot = {1'b0, shift_q,
            {(I2S_SLOT_W - 1 - DATA_W){1'b0}}};
    k     = bit_cnt_d[4:0];
    dac_d = fall ? slot[5'(I2S_SLOT_W - 1) - k] : dac_q;

    ovf_d = (bus.i_valid & ~push)
          | (ovf_q & ~bus.i_clr_flags);
    udf_d = (frame & fifo_empty)
          | (udf_q & ~bus.i_clr_flags);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      bit_cnt_q <= '0;
      lrck_q    <= 1'b0;
      dac_q     <= 1'b0;
      shift_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      bit_cnt_q <= bit_cnt_d;
      lrck_q    <= lrck_d;
      dac_q     <= dac_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  assign bus.o_bclk      = bclk_q;
  assign bus.o_lrck      = lrck_q;
  assign bus.o_dacdat    = dac_q;
  assign bus.o_fifo_full = fifo_full;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;

endmodule
